seq_detect_param: RTL and testbench

//  Parametrised serial sequence detector: watches a 1-bit stream qualified by valid and

---
 rtl/seq_detect_param.sv | 130 +++++++++++++
 tb/tb_seq_detect_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial sequence detector with a runtime-loadable pattern, overlap control and a saturating match counter.
// Optional idle timeout that clears the history: define SEQ_TIMEOUT_EN.
//
// state   | meaning
// FILLING | fewer than len valid bits collected since the last clear
// ARMED   | at least len valid bits held, so every valid bit may complete a match
module seq_detect_param #(
    parameter int                PAT_W   = 4,
    parameter int                CNT_W   = 8,
    parameter logic [PAT_W-1:0]  DEF_PAT = 4'b1101,
    parameter int                DEF_LEN = PAT_W,
    parameter int                TIMEOUT = 16,
    localparam int               LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_data,
    input  logic             valid,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cnt_clr,
    output logic             result,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic {FILLING = 1'b0, ARMED = 1'b1} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             result_q;

    logic [PAT_W-1:0] nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_inc;
    logic             len_ok;
    logic             hit;

`ifdef SEQ_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [IDLE_W-1:0] idle_q;
    logic              idle_hit;

    assign idle_hit = !valid && (idle_q == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || valid || idle_hit)
            idle_q <= '0;
        else
            idle_q <= idle_q + IDLE_W'(1);
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        nxt  = {hist_q[PAT_W-2:0], i_data};
        mask = '0;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (i < int'(len_q));

        fill_inc = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
        // ARMED already guarantees enough history; FILLING needs this bit to be the len-th
        len_ok   = (state_q == ARMED) ||
                   (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
        hit      = valid && !cfg_load && len_ok && ((nxt & mask) == (pat_q & mask));

        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            hist_d = '0;
            fill_d = '0;
        end else if (valid) begin
            hist_d = nxt;
            fill_d = (hit && !overlap) ? '0 : fill_inc;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (idle_hit) begin
            hist_d = '0;
            fill_d = '0;
        end
`endif

        state_d = (fill_d >= len_d) ? ARMED : FILLING;

        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (hit && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILLING;
            hist_q   <= '0;
            fill_q   <= '0;
            pat_q    <= DEF_PAT;
            len_q    <= LEN_W'(DEF_LEN);
            cnt_q    <= '0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            result_q <= hit;
        end
    end

    assign result    = result_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised plus directed bench for seq_detect_param; a queue-of-bits reference model feeds
// a scoreboard that a negedge monitor drains. Honours SEQ_TIMEOUT_EN when defined.
module tb_seq_detect_param;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 3;
    localparam int LEN_W   = 3;
    localparam int TIMEOUT = 2;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_data = 1'b0;
    logic             valid = 1'b0;
    logic             overlap = 1'b1;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cnt_clr = 1'b0;
    logic             result;
    logic [CNT_W-1:0] match_cnt;

    seq_detect_param #(
        .PAT_W(PAT_W), .CNT_W(CNT_W), .DEF_PAT(4'b1101), .DEF_LEN(PAT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .valid(valid), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .result(result), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit res;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: bits received since the last clear, newest at the back
    bit   m_bits[$];
    logic [PAT_W-1:0] m_pat;
    int   m_len = PAT_W;
    int   m_cnt = 0;
    int   m_idle = 0;

    task automatic step(input bit r, input bit ld, input logic [PAT_W-1:0] cp,
                        input logic [LEN_W-1:0] cl, input bit v, input bit d,
                        input bit ov, input bit clr);
        exp_t e;
        bit   res;
        rst = r; cfg_load = ld; cfg_pattern = cp; cfg_len = cl;
        valid = v; i_data = d; overlap = ov; cnt_clr = clr;

        res = 1'b0;
        if (r) begin
            m_bits.delete();
            m_pat  = 4'b1101;
            m_len  = PAT_W;
            m_cnt  = 0;
            m_idle = 0;
        end else begin
            if (ld) begin
                m_pat = cp;
                m_len = (cl == 0 || int'(cl) > PAT_W) ? PAT_W : int'(cl);
                m_bits.delete();
            end else if (v) begin
                m_bits.push_back(d);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                if (m_bits.size() >= m_len) begin
                    res = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) res = 1'b0;
                end
                if (res && !ov) m_bits.delete();
            end
            if (clr) m_cnt = 0;
            else if (res && m_cnt < CNT_SAT) m_cnt++;
`ifdef SEQ_TIMEOUT_EN
            if (v) m_idle = 0;
            else if (m_idle + 1 == TIMEOUT) begin
                m_idle = 0;
                if (!ld) m_bits.delete();
            end else m_idle++;
`endif
        end
        e.res = res;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input bit d, input bit ov);
        step(0, 0, '0, '0, 1, d, ov, 0);
    endtask

    task automatic gap();
        step(0, 0, '0, '0, 0, 0, overlap, 0);
    endtask

    task automatic bits_in(input logic [7:0] pat, input int n, input bit ov);
        logic [7:0] p;
        p = pat;
        for (int i = n - 1; i >= 0; i--) bit_in(p[i], ov);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (result !== e.res) begin
                errors++;
                $display("FAIL result at %0t: got %b expected %b", $time, result, e.res);
            end
            checks++;
            if (match_cnt !== CNT_W'(e.cnt)) begin
                errors++;
                $display("FAIL match_cnt at %0t: got %0d expected %0d", $time, match_cnt, e.cnt);
            end
        end
    end

    initial begin
        // reset state
        step(1, 0, '0, '0, 0, 0, 1, 0);
        step(1, 0, '0, '0, 1, 1, 1, 0);
        gap();
        // defaults 1101, four bits, then a gap so the pulse is seen
        bits_in(8'b1101, 4, 1); gap();
        // overlapping vs non-overlapping on 1101101
        step(1, 0, '0, '0, 0, 0, 1, 0);
        bits_in(8'b1101101, 7, 1); gap();
        step(1, 0, '0, '0, 0, 0, 0, 0);
        bits_in(8'b1101101, 7, 0); gap();
        // gaps inside a sequence
        step(1, 0, '0, '0, 0, 0, 1, 0);
        bit_in(1, 1); bit_in(1, 1); gap(); gap(); gap(); bit_in(0, 1); bit_in(1, 1); gap();
        // reload to 011 len 3, old pattern no longer hits
        step(0, 1, 4'b0011, 3'd3, 1, 1, 1, 0);
        bits_in(8'b1101, 4, 1); bits_in(8'b011, 3, 1); gap();
        // length 0 and out-of-range lengths fall back to PAT_W
        step(0, 1, 4'b1010, 3'd0, 0, 0, 1, 0);
        bits_in(8'b1010, 4, 1);
        step(0, 1, 4'b0110, 3'd7, 0, 0, 1, 0);
        bits_in(8'b0110, 4, 1); gap();
        // saturation with pattern 11, then clear colliding with a match
        step(0, 1, 4'b0011, 3'd2, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) bit_in(1, 1);
        step(0, 0, '0, '0, 1, 1, 1, 1);
        bit_in(1, 1); gap();
        // reset mid-sequence
        step(1, 0, '0, '0, 0, 0, 1, 0);
        bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
        step(1, 0, '0, '0, 1, 1, 1, 0);
        bit_in(1, 1); gap();
        // random traffic
        for (int n = 0; n < 800; n++) begin
            bit r, ld, v, d, ov, clr;
            r   = ($urandom_range(0, 99) < 1);
            ld  = ($urandom_range(0, 99) < 3);
            v   = ($urandom_range(0, 99) < 75);
            d   = $urandom_range(0, 1);
            ov  = ($urandom_range(0, 99) < 70);
            clr = ($urandom_range(0, 99) < 4);
            step(r, ld, PAT_W'($urandom_range(0, 15)), LEN_W'($urandom_range(0, 7)), v, d, ov, clr);
        end
        gap();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
